// File: rtl/score_lives_tracker.sv
// ============================================================================
// score_lives_tracker : BCD score, lives and post-crash grace window tracking
// Revision: 1.0
// ============================================================================
`default_nettype none

module score_lives_tracker #(
  parameter int START_LIVES  = 3,
  parameter int COIN_POINTS  = 1,
  parameter int GRACE_FRAMES = 60
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        EnterEn,
  input  logic        FrameTick,
  input  logic        CoinEn,
  input  logic        PoliceEn,
  output logic [11:0] Score,
  output logic [1:0]  Lives,
  output logic        Playing,
  output logic        HitFlash,
  output logic        GameOver
);

  localparam logic [1:0] c_START_LIVES  = START_LIVES[1:0];
  localparam logic [4:0] c_COIN_POINTS  = COIN_POINTS[4:0];
  localparam logic [7:0] c_GRACE_FRAMES = GRACE_FRAMES[7:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_GRACE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  grace_q, grace_d;
  logic        coin_q, pol_q;
  logic        playing_q, hitflash_q, gameover_q;

  logic        w_coin_rise, w_pol_rise;
  logic [4:0]  w_ones, w_tens, w_hund;
  logic [11:0] w_score_inc;
  logic [7:0]  w_grace_inc;

  assign w_coin_rise = CoinEn & ~coin_q;
  assign w_pol_rise  = PoliceEn & ~pol_q;
  assign w_grace_inc = grace_q + 8'd1;

  // Ripple BCD add; a hundreds overflow saturates instead of wrapping.
  always_comb begin
    w_ones = {1'b0, score_q[3:0]} + c_COIN_POINTS;
    w_tens = {1'b0, score_q[7:4]};
    w_hund = {1'b0, score_q[11:8]};
    if (w_ones > 5'd9) begin
      w_ones = w_ones - 5'd10;
      w_tens = w_tens + 5'd1;
    end
    if (w_tens > 5'd9) begin
      w_tens = w_tens - 5'd10;
      w_hund = w_hund + 5'd1;
    end
    if (w_hund > 5'd9) w_score_inc = 12'h999;
    else               w_score_inc = {w_hund[3:0], w_tens[3:0], w_ones[3:0]};
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    grace_d = grace_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (EnterEn) begin
          state_d = S_PLAY;
          score_d = 12'h000;
          lives_d = c_START_LIVES;
          grace_d = 8'd0;
        end
      end
      S_PLAY: begin
        if (w_coin_rise) score_d = w_score_inc;
        if (w_pol_rise) begin
          grace_d = 8'd0;
          if (lives_q > 2'd1) begin
            state_d = S_GRACE;
            lives_d = lives_q - 2'd1;
          end else begin
            state_d = S_OVER;
            lives_d = 2'd0;
          end
        end
      end
      S_GRACE: begin
        if (w_coin_rise) score_d = w_score_inc;
        if (FrameTick) begin
          if (w_grace_inc == c_GRACE_FRAMES) begin
            state_d = S_PLAY;
            grace_d = 8'd0;
          end else begin
            grace_d = w_grace_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      score_q    <= 12'h000;
      lives_q    <= c_START_LIVES;
      grace_q    <= 8'd0;
      coin_q     <= 1'b0;
      pol_q      <= 1'b0;
      playing_q  <= 1'b0;
      hitflash_q <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      grace_q    <= grace_d;
      coin_q     <= CoinEn;
      pol_q      <= PoliceEn;
      playing_q  <= (state_d == S_PLAY) || (state_d == S_GRACE);
      hitflash_q <= (state_d == S_GRACE);
      gameover_q <= (state_d == S_OVER);
    end
  end

  assign Score    = score_q;
  assign Lives    = lives_q;
  assign Playing  = playing_q;
  assign HitFlash = hitflash_q;
  assign GameOver = gameover_q;

endmodule

`default_nettype wire

// File: doc/score_lives_tracker.md
Name: score_lives_tracker

Overview:
- Consumes the single-cycle coin/police hit flags produced by the hit-detection stage.
- Maintains the player's BCD score and remaining lives, and runs a post-crash invulnerability window timed in frames.
- Produces the game-over and playing status used by the draw/control FSM and the HEX display drivers.

Parameters:
START_LIVES, 3, lives loaded at game start; legal range 1..3.
COIN_POINTS, 1, BCD points added per coin; legal range 1..9.
GRACE_FRAMES, 60, FrameTick pulses of invulnerability after a police hit; legal range 1..255.

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
EnterEn  in  1  start/restart request, level, sampled each clock
FrameTick  in  1  one-cycle pulse per frame (60 Hz)
CoinEn  in  1  coin-hit flag from hit detector
PoliceEn  in  1  police-hit flag from hit detector
Score  out  12  3-digit BCD score {hundreds, tens, ones}
Lives  out  2  remaining lives
Playing  out  1  high in PLAY or GRACE
HitFlash  out  1  high in GRACE (car blink enable)
GameOver  out  1  high in OVER

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, Score=12'h000, Lives=START_LIVES.
  - Grace counter=0; coin/police edge registers=0.
  - Playing=HitFlash=GameOver=0.
- Edge detection: coin_q and pol_q register CoinEn and PoliceEn every clock.
  - coin_rise = CoinEn & ~coin_q; pol_rise = PoliceEn & ~pol_q.
  - A flag held high for N cycles counts once.
  - Edge registers update in every state, so a flag already high when PLAY is entered does not count.
- States:
  - IDLE: EnterEn=1 -> PLAY; Score cleared to 000 and Lives loaded with START_LIVES on the same edge.
  - PLAY: pol_rise with Lives>1 -> GRACE, Lives-1, grace counter cleared.
    - pol_rise with Lives==1 -> OVER, Lives=0.
    - Otherwise stay in PLAY.
  - GRACE: pol_rise is ignored. The grace counter increments on each FrameTick.
    - On the FrameTick that makes the counter equal GRACE_FRAMES -> PLAY, counter cleared.
  - OVER: Score and Lives frozen; coin_rise and pol_rise ignored.
    - EnterEn=1 -> PLAY with Score=000 and Lives=START_LIVES (restart).
  - Unreachable encodings -> IDLE.
- Coin scoring:
  - coin_rise in PLAY or GRACE adds COIN_POINTS to Score as BCD.
  - Digit carry: a digit greater than 9 after the add subtracts 10 and carries into the next digit.
  - Saturation: if the sum would exceed 999, Score holds 12'h999.
- Simultaneous coin_rise and pol_rise in PLAY:
  - Both apply on the same edge (score increments, life lost).
  - If this is the last life, the coin still counts and the state goes to OVER.
- Latency: Score, Lives and status outputs are registered.
  - Each changes on the first clock edge at which the qualifying input is sampled high; it is visible in the following cycle.
  - No combinational path from any input to any output.
- Output decode:
  - Playing = (state==PLAY) | (state==GRACE).
  - HitFlash = (state==GRACE).
  - GameOver = (state==OVER).
  - All three are driven from registered state only.
- FrameTick coinciding with pol_rise in PLAY: the tick is not counted (counter starts at 0 in GRACE).
- Reset asserted mid-game: immediate return to the reset values above, regardless of state or counter value.

Test Plan:
- Reset, then EnterEn=1 for one cycle -> Playing=1, Score=000, Lives=3, GameOver=0.
- CoinEn held high for 5 cycles, then low, repeated 12 times -> Score=012 (one count per high level), digit carry at 009->010 correct.
- Preload to 998 via 998 coin pulses, then 3 more pulses -> Score 999, 999, 999 (saturates, no wrap).
- PoliceEn pulse -> Lives=2, HitFlash=1. Second PoliceEn pulse within 60 FrameTicks -> Lives stays 2. After the 60th FrameTick, HitFlash=0 and the next PoliceEn pulse gives Lives=1.
- Lives=1 and CoinEn/PoliceEn rising in the same cycle -> Score+1, Lives=0, GameOver=1, Playing=0. Further CoinEn pulses -> Score unchanged. EnterEn -> Score=000, Lives=3, Playing=1.
- resetn pulsed low asynchronously mid-GRACE (between clock edges) -> outputs reach reset values before the next clock edge; EnterEn ignored while resetn=0.
